// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one SEG-bit slice per stage.
// Define CLA_PIPE_SAT_EN to clamp the sum to the signed range on overflow.
module cla_pipe #(
    parameter int W   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int S  = W / SEG;
    localparam int NG = SEG / 4;

    // SEG-bit two-level lookahead slice: returns {carry_out, sum}
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           c
    );
        logic [SEG-1:0] g, p, cy;
        logic [NG-1:0]  gg, gp;
        logic [NG:0]    gc;
        logic           acc, prod;
        g = x & y;
        p = x | y;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = c;
        for (int j = 1; j <= NG; j++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                acc  = acc | (prod & gg[i]);
                prod = prod & gp[i];
            end
            gc[j] = acc | (prod & c);
        end
        for (int j = 0; j < NG; j++) begin
            for (int m = 0; m < 4; m++) begin
                acc  = 1'b0;
                prod = 1'b1;
                for (int i = m - 1; i >= 0; i--) begin
                    acc  = acc | (prod & g[4*j+i]);
                    prod = prod & p[4*j+i];
                end
                cy[4*j+m] = acc | (prod & gc[j]);
            end
        end
        return {gc[NG], x ^ y ^ cy};
    endfunction

    logic [S-1:0]   v_q, v_d;
    logic [S-1:0]   c_q, c_d;
    logic [W-1:0]   a_q [S];
    logic [W-1:0]   a_d [S];
    logic [W-1:0]   b_q [S];
    logic [W-1:0]   b_d [S];
    logic [W-1:0]   s_q [S];
    logic [W-1:0]   s_d [S];
    logic [S-1:0]   adv;
    logic           rdy_chain;
    logic [SEG:0]   res [S];
    logic [W-1:0]   raw;

    // Advance chain: a stage moves when empty or when its successor moves
    always_comb begin
        adv       = '0;
        rdy_chain = out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            rdy_chain = ~v_q[k] | rdy_chain;
            adv[k]    = rdy_chain;
        end
    end

    assign in_ready = adv[0];

    // Each stage adds its own segment from its registered carry-in
    always_comb begin
        for (int k = 0; k < S; k++) begin
            res[k] = seg_add(a_q[k][k*SEG +: SEG],
                             b_q[k][k*SEG +: SEG],
                             c_q[k]);
        end
    end

    // Next-state: load stage 0 from the inputs, shift the rest forward
    always_comb begin
        v_d = v_q;
        c_d = c_q;
        for (int k = 0; k < S; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
        end
        if (adv[0]) begin
            v_d[0] = in_valid;
            a_d[0] = a;
            b_d[0] = sub ? ~b : b;
            c_d[0] = sub | cin;
            s_d[0] = '0;
        end
        for (int k = 1; k < S; k++) begin
            if (adv[k]) begin
                v_d[k] = v_q[k-1];
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
                c_d[k] = res[k-1][SEG];
                s_d[k] = s_q[k-1];
                s_d[k][(k-1)*SEG +: SEG] = res[k-1][SEG-1:0];
            end
        end
    end

    // Stage registers; reset empties the pipe and zeroes the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < S; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < S; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    // Result: last stage's slice merged with the completed lower segments
    always_comb begin
        raw                 = s_q[S-1];
        raw[W-1 -: SEG]     = res[S-1][SEG-1:0];
        cout                = res[S-1][SEG];
        ovf                 = a_q[S-1][W-1] ^ b_q[S-1][W-1]
                            ^ raw[W-1] ^ cout;
        out_valid           = v_q[S-1];
`ifdef CLA_PIPE_SAT_EN
        if (ovf)
            sum = a_q[S-1][W-1] ? {1'b1, {(W-1){1'b0}}}
                                : {1'b0, {(W-1){1'b1}}};
        else
            sum = raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: tb/tb_cla_pipe.sv
// Testbench for cla_pipe: directed table, backpressure, reset and
// randomized traffic against an integer-arithmetic reference model.
module tb_cla_pipe;

    localparam int W   = 32;
    localparam int SEG = 8;
    localparam int S   = W / SEG;
`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk, rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  a, b;
    logic          cin, sub;
    logic          out_valid, out_ready;
    logic [W-1:0]  sum;
    logic          cout, ovf;

    cla_pipe #(.W(W), .SEG(SEG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic [31:0] ssum;
        logic        cout;
        logic        ovf;
    } vec_t;

    res_t expq[$];
    res_t mon_e;
    res_t hold_r;
    bit   hold_v = 1'b0;
    bit   mark_first = 1'b0;
    bit   bp_en = 1'b0;
    int   checks = 0, errors = 0;
    int   accepted = 0, stalls = 0;
    int   cyc = 0, ndeliv = 0;
    int   first_cyc = 0, last_cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (bp_en) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic s);
        longint sx, sy, ex, ux, uy;
        res_t   r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        if (s) begin
            ex     = sx - sy;
            r.cout = (ux >= uy);
        end else begin
            ex     = sx + sy + longint'(ci);
            r.cout = ((ux + uy + longint'(ci)) >> 32) != 0;
        end
        r.ovf = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        r.sum = ex[31:0];
        if (SAT && r.ovf)
            r.sum = (ex > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return r;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic s, input res_t e);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a = x; b = y; cin = ci; sub = s;
        for (int n = 0; n < 200 && !acc; n++) begin
            if (n > 0) begin
                @(negedge clk);
                stalls++;
            end
            acc = in_ready;
            @(posedge clk);
        end
        if (acc) begin
            expq.push_back(e);
            accepted++;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 exp 1");
        end
    endtask

    task automatic send_rand();
        logic [31:0] x, y;
        logic        ci, s;
        x  = rnd32();
        y  = rnd32();
        ci = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        send(x, y, ci, s, model(x, y, ci, s));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && expq.size() != 0; i++)
            @(posedge clk);
        chk("drain_left", 64'(expq.size()), 64'd0);
        #1;
    endtask

    // Output monitor: in-order scoreboard plus hold-stability check
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!out_valid || sum !== hold_r.sum ||
                    cout !== hold_r.cout || ovf !== hold_r.ovf) begin
                    errors++;
                    $display("FAIL hold got v=%b sum=%h exp v=1 sum=%h",
                             out_valid, sum, hold_r.sum);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious got sum=%h exp no output", sum);
                end else begin
                    mon_e = expq.pop_front();
                    if (sum !== mon_e.sum || cout !== mon_e.cout ||
                        ovf !== mon_e.ovf) begin
                        errors++;
                        $display("FAIL result got sum=%h c=%b o=%b exp sum=%h c=%b o=%b",
                                 sum, cout, ovf, mon_e.sum, mon_e.cout, mon_e.ovf);
                    end
                    ndeliv++;
                    if (mark_first) begin
                        first_cyc  = cyc;
                        mark_first = 1'b0;
                    end
                    last_cyc = cyc;
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_r.sum  = sum;
            hold_r.cout = cout;
            hold_r.ovf  = ovf;
        end
    end

    vec_t tbl[11];
    res_t te;
    int   acc_cyc, base, d0, s0;
    bit   seen;

    initial begin
        tbl[0]  = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[1]  = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[2]  = '{32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[3]  = '{32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 32'h2, 1'b1, 1'b0};
        tbl[4]  = '{32'h0, 32'h0, 1'b1, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0};
        tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 1'b1, 1'b1};
        tbl[6]  = '{32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        tbl[7]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 32'h9999_9999, 1'b0, 1'b0};
        tbl[8]  = '{32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[9]  = '{32'h0000_00FF, 32'h1, 1'b1, 1'b0, 32'h101, 32'h101, 1'b0, 1'b0};
        tbl[10] = '{32'h00FF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed table; the first entry also measures latency
        for (int i = 0; i < 11; i++) begin
            te.sum  = SAT ? tbl[i].ssum : tbl[i].sum;
            te.cout = tbl[i].cout;
            te.ovf  = tbl[i].ovf;
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, te);
            if (i == 0) begin
                #1 acc_cyc = cyc;
                idle();
                for (int n = 0; n < 20 && !out_valid; n++)
                    @(negedge clk);
                chk("latency_edges", 64'(cyc - acc_cyc), 64'(S - 1));
            end
        end
        idle();
        drain();

        // Eight back-to-back with the consumer stalled for six cycles
        @(posedge clk); #1;
        out_ready = 1'b0;
        base = accepted;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("stall_accepts", 64'(accepted - base), 64'd4);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_total", 64'(accepted - base), 64'd8);

        // Reset with three transactions in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        idle();
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_sum", 64'({sum, cout, ovf}), 64'd0);
        expq.delete();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("no_stale_out", 64'(seen), 64'd0);

        // 1000 random transactions at full throughput
        @(posedge clk); #1;
        out_ready  = 1'b1;
        d0         = ndeliv;
        s0         = stalls;
        mark_first = 1'b1;
        for (int i = 0; i < 1000; i++) send_rand();
        idle();
        drain();
        chk("rand_delivered", 64'(ndeliv - d0), 64'd1000);
        chk("rand_stalls", 64'(stalls - s0), 64'd0);
        chk("rand_consecutive", 64'(last_cyc - first_cyc), 64'd999);

        // Random backpressure
        d0    = ndeliv;
        bp_en = 1'b1;
        for (int i = 0; i < 200; i++) send_rand();
        idle();
        bp_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
        chk("bp_delivered", 64'(ndeliv - d0), 64'd200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
